fft_frame_sequencer: RTL

- Sequences ADC sample frames into the FFT core and sets the frame rate of the FFT -> half-spectrum filter -> CORDIC chain.
- Before each frame it sends one FFT config word on the FFT config channel.
- It then passes exactly FFT_LENGTH ADC samples into the FFT, with tlast on the last sample.
- It counts frames still in flight by watching tlast on the CORDIC input channel (last sample of each half-spectrum frame), and stalls new frames once MAX_INFLIGHT is reached.

---
 rtl/fft_frame_sequencer_if.sv | 16 +
 rtl/fft_frame_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer_if.sv
// Stream channel bundle (data/valid/ready/last) used between the frame sequencer and its neighbours.
// The modports without tlast serve channels that carry no framing.
interface fft_frame_sequencer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master  (output tdata, output tvalid, output tlast, input  tready);
  modport slave   (input  tdata, input  tvalid, input  tlast, output tready);
  modport source  (output tdata, output tvalid, input  tready);
  modport sink    (input  tdata, input  tvalid, output tready);
  modport monitor (input  tvalid, input  tready, input  tlast);
endinterface

// File: rtl/fft_frame_sequencer.sv
// Feeds ADC frames into the FFT, one config word ahead of each frame, and paces launches
// against frames still travelling through the FFT -> half-spectrum -> CORDIC chain.
module fft_frame_sequencer #(
  parameter int FFT_LENGTH   = 512,
  parameter int SAMPLE_WIDTH = 16,
  parameter int CFG_WIDTH    = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic [CFG_WIDTH-1:0] cfg_word,
  fft_frame_sequencer_if.sink    adc,
  fft_frame_sequencer_if.source  fft_cfg,
  fft_frame_sequencer_if.master  fft,
  fft_frame_sequencer_if.monitor mon,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic [2:0]           inflight,
  output logic                 busy,
  output logic                 err_underflow
);

  localparam int              CNT_W    = $clog2(FFT_LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FFT_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [2:0]       MAX_IF   = 3'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CFG    = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [CFG_WIDTH-1:0] cfg_r;
  logic [2:0]           inflight_r;
  logic [15:0]          frame_count_r;
  logic                 frame_done_r;
  logic                 err_underflow_r;

  logic       stream_s;
  logic       last_s;
  logic       fft_hs_s;
  logic       launch_s;
  logic       mon_ev_s;
  logic       mon_ok_s;
  logic [2:0] inflight_next_s;

  assign stream_s = (state_r == ST_STREAM);
  assign last_s   = stream_s && (cnt_r == CNT_LAST);
  assign fft_hs_s = stream_s && adc.tvalid && fft.tready;
  assign launch_s = fft_hs_s && last_s;
  assign mon_ev_s = mon.tvalid && mon.tready && mon.tlast;
  assign mon_ok_s = mon_ev_s && (inflight_r != 3'd0);

  // Samples pass straight through while streaming; every other state back-pressures the ADC.
  assign adc.tready     = stream_s && fft.tready;
  assign fft.tvalid     = stream_s && adc.tvalid;
  assign fft.tdata      = {{SAMPLE_WIDTH{1'b0}}, adc.tdata};
  assign fft.tlast      = last_s;
  assign fft_cfg.tvalid = (state_r == ST_CFG);
  assign fft_cfg.tdata  = cfg_r;

  assign frame_done    = frame_done_r;
  assign frame_count   = frame_count_r;
  assign inflight      = inflight_r;
  assign busy          = (state_r != ST_IDLE);
  assign err_underflow = err_underflow_r;

  // Next in-flight count: a launch and a retire in the same cycle cancel out.
  always_comb begin
    inflight_next_s = inflight_r;
    if (launch_s && !mon_ok_s) begin
      inflight_next_s = inflight_r + 3'd1;
    end else if (!launch_s && mon_ok_s) begin
      inflight_next_s = inflight_r - 3'd1;
    end else begin
      inflight_next_s = inflight_r;
    end
  end

  // Frame sequencing FSM: config beat, FFT_LENGTH samples, then decide on the next frame.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      cfg_r   <= {CFG_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            cfg_r   <= cfg_word;
            state_r <= ST_CFG;
          end
        end
        ST_CFG: begin
          if (fft_cfg.tready) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (fft_hs_s) begin
            if (last_s) begin
              cnt_r <= CNT_ZERO;
              // Decide on the projected count so a full pipeline never gets one more launch.
              if (!enable) begin
                state_r <= ST_IDLE;
              end else if (inflight_next_s >= MAX_IF) begin
                state_r <= ST_WAIT;
              end else begin
                cfg_r   <= cfg_word;
                state_r <= ST_CFG;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        ST_WAIT: begin
          if (inflight_r < MAX_IF) begin
            if (enable) begin
              cfg_r   <= cfg_word;
              state_r <= ST_CFG;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion tracking from the CORDIC-input tap; a retire with nothing in flight is flagged.
  always_ff @(posedge aclk) begin
    if (areset) begin
      inflight_r      <= 3'd0;
      frame_count_r   <= 16'd0;
      frame_done_r    <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      inflight_r   <= inflight_next_s;
      frame_done_r <= mon_ok_s;
      if (mon_ok_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
      if (mon_ev_s && !mon_ok_s) begin
        err_underflow_r <= 1'b1;
      end
    end
  end

endmodule
